// File: rtl/ad_ip_jesd204_tpl_dac_framer_pkg.sv
// Shared encodings for the DAC transport-layer framer: source selects, PN seeds,
// sync FSM states and the PN bit-placement helper.
package ad_ip_jesd204_tpl_dac_framer_pkg;

  localparam logic [3:0] SEL_DMA  = 4'd0;
  localparam logic [3:0] SEL_ZERO = 4'd1;
  localparam logic [3:0] SEL_PN7  = 4'd2;
  localparam logic [3:0] SEL_PN15 = 4'd3;

  localparam logic [6:0]  PN7_SEED  = 7'h7f;
  localparam logic [14:0] PN15_SEED = 15'h7fff;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ARMED = 1'b1
  } sync_state_e;

  // j-th generated PN bit lands in sample j/np, counted from that sample's MSB
  function automatic int pn_bit_pos(input int j, input int np);
    return (j / np) * np + np - 1 - (j % np);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_framer_pn.sv
// Per-channel PN7 / PN15 generator producing DW bits per beat, first bit in the
// MSB of sample 0. State holds the oldest window of the sequence, oldest bit in [0].
module ad_ip_jesd204_tpl_dac_pn
  import ad_ip_jesd204_tpl_dac_framer_pkg::*;
#(
  parameter int DW = 16,
  parameter int NP = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          advance_i,
  input  logic          reseed_i,
  output logic [DW-1:0] pn7_o,
  output logic [DW-1:0] pn15_o
);

  localparam int AW = $clog2(DW);

  logic [6:0]  pn7_q,  pn7_d;
  logic [14:0] pn15_q, pn15_d;

  always_comb begin
    logic [6:0]    s7;
    logic [14:0]   s15;
    logic [AW-1:0] idx;
    s7     = pn7_q;
    s15    = pn15_q;
    idx    = '0;
    pn7_o  = '0;
    pn15_o = '0;
    // b[n] = b[n-6]^b[n-7] and b[n] = b[n-14]^b[n-15] both reduce to window[1]^window[0]
    for (int j = 0; j < DW; j++) begin
      idx         = AW'(pn_bit_pos(j, NP));
      pn7_o[idx]  = s7[0];
      pn15_o[idx] = s15[0];
      s7          = {s7[1] ^ s7[0], s7[6:1]};
      s15         = {s15[1] ^ s15[0], s15[14:1]};
    end
    pn7_d  = pn7_q;
    pn15_d = pn15_q;
    if (reseed_i) begin
      pn7_d  = PN7_SEED;
      pn15_d = PN15_SEED;
    end else if (advance_i) begin
      pn7_d  = s7;
      pn15_d = s15;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pn7_q  <= PN7_SEED;
      pn15_q <= PN15_SEED;
    end else begin
      pn7_q  <= pn7_d;
      pn15_q <= pn15_d;
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// JESD204 TX transport-layer framer: per-channel source select, frame packing into
// lane octets, and the optional external-sync arm/trigger FSM.
//   state    | meaning
//   ST_RUN   | samples requested and framed onto the link
//   ST_ARMED | waiting for trigger; link carries zeros, no sample requests
module ad_ip_jesd204_tpl_dac_framer
  import ad_ip_jesd204_tpl_dac_framer_pkg::*;
#(
  parameter int NUM_LANES         = 1,
  parameter int NUM_CHANNELS      = 2,
  parameter int BITS_PER_SAMPLE   = 16,
  parameter int SAMPLES_PER_FRAME = 1,
  parameter int OCTETS_PER_BEAT   = 4,
  parameter int EXT_SYNC          = 0,
  parameter int PN7_ENABLE        = 1,
  parameter int PN15_ENABLE       = 1
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic [NUM_CHANNELS-1:0]                   enable,
  input  logic [4*NUM_CHANNELS-1:0]                 dac_data_sel,
  input  logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0]    dac_ddata,
  input  logic                                      dac_dunf,
  output logic [NUM_CHANNELS-1:0]                   dac_valid,
  input  logic                                      dac_sync,
  input  logic                                      dac_sync_in,
  input  logic                                      dac_ext_sync_arm,
  input  logic                                      dac_ext_sync_disarm,
  input  logic                                      dac_sync_manual_req,
  output logic                                      dac_sync_status,
  output logic                                      link_valid,
  input  logic                                      link_ready,
  output logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0]    link_data
);

  localparam int NP  = BITS_PER_SAMPLE;
  localparam int S   = SAMPLES_PER_FRAME;
  localparam int LDW = NUM_LANES * OCTETS_PER_BEAT * 8;
  localparam int DW  = LDW / NUM_CHANNELS;
  localparam int F   = NUM_CHANNELS * NP * S / (8 * NUM_LANES);
  localparam int FPB = OCTETS_PER_BEAT / F;
  localparam int WW  = NUM_CHANNELS * S * NP;

  sync_state_e       state_q, state_d;
  logic              sync_in_q, manual_q;
  logic              link_valid_q;
  logic [LDW-1:0]    link_data_q;
  logic              run, accept, trigger, pn_reseed, pn_advance;
  logic [LDW-1:0]    samp_all;
  logic [LDW-1:0]    beat_data;
  logic [FPB-1:0][WW-1:0] frame_word;

  assign accept  = link_valid_q & link_ready;
  assign trigger = (dac_sync_in & ~sync_in_q) | (dac_sync_manual_req & ~manual_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (EXT_SYNC != 0) begin
      state_d = state_q;
      case (state_q)
        ST_RUN:   if (dac_ext_sync_arm & ~dac_ext_sync_disarm) state_d = ST_ARMED;
        ST_ARMED: if (dac_ext_sync_disarm | trigger) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    run             = (state_q == ST_RUN);
    dac_sync_status = (state_q == ST_ARMED);
    pn_reseed       = dac_sync | (state_q != state_d);
    pn_advance      = accept & run;
  end

  // gated by link_valid so a request is never issued for a beat that cannot be accepted
  assign dac_valid = {NUM_CHANNELS{link_ready & link_valid_q & run}};

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [DW-1:0] pn7, pn15, samp;
    logic [3:0]    sel;

    assign sel = dac_data_sel[c*4 +: 4];

    ad_ip_jesd204_tpl_dac_pn #(
      .DW (DW),
      .NP (NP)
    ) i_pn (
      .clk       (clk),
      .resetn    (resetn),
      .advance_i (pn_advance),
      .reseed_i  (pn_reseed),
      .pn7_o     (pn7),
      .pn15_o    (pn15)
    );

    always_comb begin
      samp = '0;
      if (enable[c]) begin
        case (sel)
          SEL_DMA:  samp = dac_dunf ? '0 : dac_ddata[c*DW +: DW];
          SEL_ZERO: samp = '0;
          SEL_PN7:  samp = (PN7_ENABLE != 0) ? pn7 : '0;
          SEL_PN15: samp = (PN15_ENABLE != 0) ? pn15 : '0;
          default:  samp = '0;
        endcase
      end
    end

    assign samp_all[c*DW +: DW] = samp;
  end

  // frame word is MSB-first {ch0_s0..ch0_sS-1, ch1_s0, ...}; lane 0 owns its top F octets
  for (genvar f = 0; f < FPB; f++) begin : g_frame
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_c
      for (genvar s = 0; s < S; s++) begin : g_s
        assign frame_word[f][(NUM_CHANNELS*S-1-(c*S+s))*NP +: NP] =
          samp_all[c*DW + (f*S+s)*NP +: NP];
      end
    end
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      for (genvar j = 0; j < F; j++) begin : g_oct
        assign beat_data[(l*OCTETS_PER_BEAT + f*F + j)*8 +: 8] =
          frame_word[f][((NUM_LANES-l)*F-1-j)*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      sync_in_q    <= 1'b1;
      manual_q     <= 1'b1;
    end else begin
      link_valid_q <= 1'b1;
      sync_in_q    <= dac_sync_in;
      manual_q     <= dac_sync_manual_req;
      if (accept) link_data_q <= run ? beat_data : '0;
    end
  end

  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer.sv
// Bench for the DAC framer (L=1, M=2, NP=16, S=1, OPB=4, EXT_SYNC=1) against a
// sequence-level reference model of sources, PN streams, octet order and sync FSM.
module tb_ad_ip_jesd204_tpl_dac_framer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  enable;
  logic [7:0]  dac_data_sel;
  logic [31:0] dac_ddata;
  logic        dac_dunf;
  logic [1:0]  dac_valid;
  logic        dac_sync;
  logic        dac_sync_in;
  logic        dac_ext_sync_arm;
  logic        dac_ext_sync_disarm;
  logic        dac_sync_manual_req;
  logic        dac_sync_status;
  logic        link_valid;
  logic        link_ready;
  logic [31:0] link_data;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_framer #(
    .NUM_LANES(1), .NUM_CHANNELS(2), .BITS_PER_SAMPLE(16), .SAMPLES_PER_FRAME(1),
    .OCTETS_PER_BEAT(4), .EXT_SYNC(1), .PN7_ENABLE(1), .PN15_ENABLE(1)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .enable              (enable),
    .dac_data_sel        (dac_data_sel),
    .dac_ddata           (dac_ddata),
    .dac_dunf            (dac_dunf),
    .dac_valid           (dac_valid),
    .dac_sync            (dac_sync),
    .dac_sync_in         (dac_sync_in),
    .dac_ext_sync_arm    (dac_ext_sync_arm),
    .dac_ext_sync_disarm (dac_ext_sync_disarm),
    .dac_sync_manual_req (dac_sync_manual_req),
    .dac_sync_status     (dac_sync_status),
    .link_valid          (link_valid),
    .link_ready          (link_ready),
    .link_data           (link_data)
  );

  int checks = 0;
  int errors = 0;

  bit b7  [127];
  bit b15 [32767];

  bit          m_lv;
  logic [31:0] m_ld;
  bit          m_armed;
  bit          m_prev_in, m_prev_man;
  int          m_k;

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  function automatic logic [15:0] pn_word(input bit is15, input int k);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      w[15-i] = is15 ? b15[(16*k+i) % 32767] : b7[(16*k+i) % 127];
    return w;
  endfunction

  function automatic logic [15:0] chan_val(input int c);
    logic [3:0] sel;
    sel = dac_data_sel[4*c +: 4];
    if (!enable[c]) return 16'h0;
    case (sel)
      4'd0:    return dac_dunf ? 16'h0 : dac_ddata[16*c +: 16];
      4'd2:    return pn_word(1'b0, m_k);
      4'd3:    return pn_word(1'b1, m_k);
      default: return 16'h0;
    endcase
  endfunction

  // frame word {ch0,ch1}; octet j (sent j-th) is taken from the top down
  function automatic logic [31:0] pack(input logic [15:0] c0, input logic [15:0] c1);
    logic [31:0] word, r;
    word = {c0, c1};
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = word[31-8*j -: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_lv = 1'b0; m_ld = '0; m_armed = 1'b0;
    m_prev_in = 1'b1; m_prev_man = 1'b1; m_k = 0;
  endtask

  task automatic cyc(input string tag);
    bit acc, nxt_armed, rise, reseed;
    logic [15:0] v0, v1;
    #1;
    if (m_lv) check(tag, "dac_valid", 32'(dac_valid), (link_ready && !m_armed) ? 32'h3 : 32'h0);
    acc  = m_lv && link_ready;
    v0   = chan_val(0);
    v1   = chan_val(1);
    rise = (dac_sync_in && !m_prev_in) || (dac_sync_manual_req && !m_prev_man);
    if (m_armed) nxt_armed = !(dac_ext_sync_disarm || rise);
    else         nxt_armed = dac_ext_sync_arm && !dac_ext_sync_disarm;
    reseed = dac_sync || (nxt_armed != m_armed);
    m_prev_in  = dac_sync_in;
    m_prev_man = dac_sync_manual_req;
    @(posedge clk);
    #1;
    if (acc) m_ld = m_armed ? 32'h0 : pack(v0, v1);
    if (reseed) m_k = 0;
    else if (acc && !m_armed) m_k++;
    m_armed = nxt_armed;
    m_lv    = 1'b1;
    check(tag, "link_data", link_data, m_ld);
    check(tag, "link_valid", 32'(link_valid), 32'(m_lv));
    check(tag, "status", 32'(dac_sync_status), 32'(m_armed));
  endtask

  task automatic clear_pulses();
    dac_sync = 1'b0; dac_ext_sync_arm = 1'b0; dac_ext_sync_disarm = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 127; n++) b7[n] = (n < 7) ? 1'b1 : (b7[n-6] ^ b7[n-7]);
    for (int n = 0; n < 32767; n++) b15[n] = (n < 15) ? 1'b1 : (b15[n-14] ^ b15[n-15]);

    resetn = 1'b0; enable = 2'b11; dac_data_sel = 8'h00; dac_ddata = '0; dac_dunf = 1'b0;
    dac_sync_in = 1'b0; dac_sync_manual_req = 1'b0; link_ready = 1'b1;
    clear_pulses();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", "link_valid", 32'(link_valid), 32'h0);
    check("reset", "link_data", link_data, 32'h0);
    check("reset", "dac_valid", 32'(dac_valid), 32'h0);
    check("reset", "status", 32'(dac_sync_status), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("release", "link_valid", 32'(link_valid), 32'h0);
    cyc("first");

    // DMA pass-through and octet order
    dac_ddata = {16'hABCD, 16'h1234};
    cyc("dma");
    check("dma", "const", link_data, 32'hCDAB3412);
    check("dma", "dac_valid", 32'(dac_valid), 32'h3);

    // stall holds data
    link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dac_ddata = $urandom;
      cyc("stall");
    end
    check("stall", "const", link_data, 32'hCDAB3412);
    link_ready = 1'b1;
    dac_ddata = $urandom;
    cyc("resume");

    // PN sources after reseed
    dac_data_sel = 8'h32;
    dac_sync = 1'b1;
    cyc("pn_sync");
    clear_pulses();
    cyc("pn_first");
    check("pn_first", "const", link_data, 32'hFEFF04FE);
    link_ready = 1'b0;
    repeat (3) cyc("pn_stall");
    link_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      link_ready = ($urandom_range(0, 3) != 0);
      cyc("pn_run");
    end
    link_ready = 1'b1;

    // external sync: pre-high level does not trigger, rising edge does
    dac_data_sel = 8'h00;
    dac_ddata = $urandom;
    dac_sync_in = 1'b1;
    cyc("trig_in_run");
    dac_ext_sync_arm = 1'b1;
    cyc("arm");
    clear_pulses();
    check("arm", "const", 32'(dac_sync_status), 32'h1);
    repeat (2) begin dac_ddata = $urandom; cyc("armed"); end
    check("armed", "const", link_data, 32'h0);
    dac_sync_in = 1'b0;
    cyc("armed_low");
    dac_sync_in = 1'b1;
    cyc("trig");
    check("trig", "const", 32'(dac_sync_status), 32'h0);
    dac_ddata = 32'h5A5A_C3C3;
    cyc("trig_data");
    check("trig_data", "const", link_data, 32'h5A5AC3C3);

    // manual trigger, then arm+disarm together
    dac_ext_sync_arm = 1'b1;
    cyc("arm2");
    clear_pulses();
    dac_sync_manual_req = 1'b1;
    cyc("manual");
    dac_sync_manual_req = 1'b0;
    dac_ext_sync_arm = 1'b1; dac_ext_sync_disarm = 1'b1;
    cyc("arm_disarm");
    clear_pulses();
    check("arm_disarm", "const", 32'(dac_sync_status), 32'h0);

    // underflow zeroes DMA channels only
    dac_data_sel = 8'h20;
    dac_dunf = 1'b1;
    dac_ddata = 32'hFFFF_FFFF;
    cyc("dunf");
    dac_dunf = 1'b0;
    cyc("dunf_off");

    // random mix
    for (int i = 0; i < 400; i++) begin
      link_ready          = ($urandom_range(0, 3) != 0);
      enable              = 2'($urandom);
      dac_data_sel        = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      dac_ddata           = $urandom;
      dac_dunf            = ($urandom_range(0, 7) == 0);
      dac_sync            = ($urandom_range(0, 15) == 0);
      dac_ext_sync_arm    = ($urandom_range(0, 9) == 0);
      dac_ext_sync_disarm = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) dac_sync_in = ~dac_sync_in;
      if ($urandom_range(0, 7) == 0) dac_sync_manual_req = ~dac_sync_manual_req;
      cyc("rand");
    end
    clear_pulses();

    // async reset mid-stall
    dac_ext_sync_arm = 1'b1;
    link_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst", "link_valid", 32'(link_valid), 32'h0);
    check("async_rst", "link_data", link_data, 32'h0);
    check("async_rst", "dac_valid", 32'(dac_valid), 32'h0);
    check("async_rst", "status", 32'(dac_sync_status), 32'h0);
    clear_pulses();
    dac_sync_in = 1'b0; dac_sync_manual_req = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    link_ready = 1'b1;
    dac_data_sel = 8'h32;
    enable = 2'b11;
    cyc("post_rst");
    repeat (4) cyc("post_rst_pn");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
